// File: rtl/m_ifetch.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// latches fetched words into the IF/ID register, with stall/redirect/halt.
module m_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          AW       = 12
) (
  input  logic          w_clk,
  input  logic          w_rst,
  input  logic          w_stall,
  input  logic          w_redirect,
  input  logic [31:0]   w_target,
  input  logic          w_halt,
  output logic [AW-1:0] w_imem_addr,
  input  logic [31:0]   w_imem_rdata,
  output logic [31:0]   w_pc,
  output logic [31:0]   w_ifid_pc,
  output logic [31:0]   w_ifid_pc4,
  output logic [31:0]   w_ifid_ir,
  output logic          w_ifid_valid,
  output logic [31:0]   w_fetch_cnt
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_ir_q, ifid_ir_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] target_aligned;
  logic [31:0] pc_plus4;

  // Misaligned redirect targets are forced onto a word boundary.
  assign target_aligned = w_target & 32'hFFFF_FFFC;
  assign pc_plus4       = pc_q + 32'd4;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'd0;
      ifid_pc4_q   <= 32'd0;
      ifid_ir_q    <= 32'd0;
      ifid_valid_q <= 1'b0;
      fetch_cnt_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_ir_q    <= ifid_ir_d;
      ifid_valid_q <= ifid_valid_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = w_halt ? S_HALT : S_RUN;
      S_RUN:   if (w_halt) state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_ir_d    = ifid_ir_q;
    ifid_valid_d = ifid_valid_q;
    fetch_cnt_d  = fetch_cnt_q;
    case (state_q)
      S_BOOT: begin
        ifid_valid_d = 1'b0;
        if (!w_halt && w_redirect) pc_d = target_aligned;
      end
      S_RUN: begin
        if (w_halt) begin
          ifid_valid_d = 1'b0;
        end else if (w_redirect) begin
          // Flush the wrong-path word; redirect wins over a decode stall.
          pc_d         = target_aligned;
          ifid_ir_d    = 32'd0;
          ifid_valid_d = 1'b0;
        end else if (!w_stall) begin
          ifid_pc_d    = pc_q;
          ifid_pc4_d   = pc_plus4;
          ifid_ir_d    = w_imem_rdata;
          ifid_valid_d = 1'b1;
          pc_d         = pc_plus4;
          fetch_cnt_d  = fetch_cnt_q + 32'd1;
        end
      end
      default: ifid_valid_d = 1'b0;
    endcase
  end

  assign w_imem_addr  = pc_q[AW+1:2];
  assign w_pc         = pc_q;
  assign w_ifid_pc    = ifid_pc_q;
  assign w_ifid_pc4   = ifid_pc4_q;
  assign w_ifid_ir    = ifid_ir_q;
  assign w_ifid_valid = ifid_valid_q;
  assign w_fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_m_ifetch.sv
// Directed bench for m_ifetch: a small behavioural model feeds a scoreboard
// queue at drive time; entries are popped and compared after each edge.
module tb_m_ifetch;

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic        w_stall = 1'b0, w_redirect = 1'b0, w_halt = 1'b0;
  logic [31:0] w_target = 32'd0;
  logic [11:0] w_imem_addr;
  logic [31:0] w_imem_rdata, w_pc, w_ifid_pc, w_ifid_pc4, w_ifid_ir, w_fetch_cnt;
  logic        w_ifid_valid;

  logic        b_stall = 1'b0, b_redirect = 1'b0, b_halt = 1'b0;
  logic [31:0] b_target = 32'd0;
  logic [11:0] b_imem_addr;
  logic [31:0] b_imem_rdata, b_pc, b_ifid_pc, b_ifid_pc4, b_ifid_ir, b_fetch_cnt;
  logic        b_ifid_valid;

  logic [31:0] mem [0:4095];
  assign w_imem_rdata = mem[w_imem_addr];
  assign b_imem_rdata = mem[b_imem_addr];

  always #5 w_clk = ~w_clk;

  m_ifetch dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_stall(w_stall), .w_redirect(w_redirect),
    .w_target(w_target), .w_halt(w_halt), .w_imem_addr(w_imem_addr),
    .w_imem_rdata(w_imem_rdata), .w_pc(w_pc), .w_ifid_pc(w_ifid_pc),
    .w_ifid_pc4(w_ifid_pc4), .w_ifid_ir(w_ifid_ir), .w_ifid_valid(w_ifid_valid),
    .w_fetch_cnt(w_fetch_cnt)
  );

  m_ifetch #(.RESET_PC(32'h0000FFFC), .AW(12)) dut_hi (
    .w_clk(w_clk), .w_rst(w_rst), .w_stall(b_stall), .w_redirect(b_redirect),
    .w_target(b_target), .w_halt(b_halt), .w_imem_addr(b_imem_addr),
    .w_imem_rdata(b_imem_rdata), .w_pc(b_pc), .w_ifid_pc(b_ifid_pc),
    .w_ifid_pc4(b_ifid_pc4), .w_ifid_ir(b_ifid_ir), .w_ifid_valid(b_ifid_valid),
    .w_fetch_cnt(b_fetch_cnt)
  );

  typedef struct packed {
    logic [31:0] pc, ipc, ipc4, ir, cnt;
    logic        v;
  } exp_t;

  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  // reference model state: 0 boot, 1 run, 2 halt
  int          m_st;
  logic [31:0] m_pc, m_ipc, m_ipc4, m_ir, m_cnt;
  logic        m_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = 32'd0; m_ipc = 32'd0; m_ipc4 = 32'd0;
    m_ir = 32'd0; m_v = 1'b0; m_cnt = 32'd0;
  endtask

  task automatic step(input string tag);
    exp_t e;
    case (m_st)
      0: begin
        if (w_halt) m_st = 2;
        else begin
          if (w_redirect) m_pc = {w_target[31:2], 2'b00};
          m_st = 1;
        end
      end
      1: begin
        if (w_halt) begin m_st = 2; m_v = 1'b0; end
        else if (w_redirect) begin
          m_pc = {w_target[31:2], 2'b00}; m_ir = 32'd0; m_v = 1'b0;
        end else if (!w_stall) begin
          m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_ir = mem[m_pc[13:2]];
          m_v = 1'b1; m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
        end
      end
      default: m_v = 1'b0;
    endcase
    exp_q.push_back('{pc: m_pc, ipc: m_ipc, ipc4: m_ipc4, ir: m_ir, cnt: m_cnt, v: m_v});
    @(posedge w_clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".pc"}, w_pc, e.pc);
    chk({tag, ".addr"}, {20'd0, w_imem_addr}, {20'd0, e.pc[13:2]});
    chk({tag, ".ifid_pc"}, w_ifid_pc, e.ipc);
    chk({tag, ".ifid_pc4"}, w_ifid_pc4, e.ipc4);
    chk({tag, ".ifid_ir"}, w_ifid_ir, e.ir);
    chk({tag, ".valid"}, {31'd0, w_ifid_valid}, {31'd0, e.v});
    chk({tag, ".cnt"}, w_fetch_cnt, e.cnt);
  endtask

  task automatic set_in(input logic st, input logic rd, input logic [31:0] tg, input logic hl);
    w_stall = st; w_redirect = rd; w_target = tg; w_halt = hl;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = {20'hC0DE0, i[11:0]};
    mem[0] = 32'h00000020; mem[1] = 32'h20090055;
    mem[2] = 32'hAC090020; mem[3] = 32'h8C070020;
    model_reset();

    #12;
    chk("rst.pc", w_pc, 32'h0);
    chk("rst.valid", {31'd0, w_ifid_valid}, 32'd0);
    chk("rst.ir", w_ifid_ir, 32'h0);
    chk("rst.cnt", w_fetch_cnt, 32'h0);
    chk("rst_hi.pc", b_pc, 32'h0000FFFC);
    chk("rst_hi.addr", {20'd0, b_imem_addr}, 32'h00000FFF);
    w_rst = 1'b0;

    step("boot");
    chk("hi_boot.pc", b_pc, 32'h0000FFFC);
    chk("hi_boot.valid", {31'd0, b_ifid_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step("fetch");
      if (k == 0) begin
        chk("hi_wrap.ifid_pc", b_ifid_pc, 32'h0000FFFC);
        chk("hi_wrap.ir", b_ifid_ir, 32'hC0DE0FFF);
        chk("hi_wrap.pc", b_pc, 32'h00010000);
        chk("hi_wrap.addr", {20'd0, b_imem_addr}, 32'd0);
      end
    end
    chk("seq.ir3", w_ifid_ir, 32'h8C070020);
    chk("seq.pc16", w_pc, 32'd16);
    chk("seq.cnt4", w_fetch_cnt, 32'd4);

    set_in(1'b0, 1'b1, 32'h8, 1'b0); step("redir8");
    set_in(1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) step("stall");
    chk("stall.pc8", w_pc, 32'd8);
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    step("unstall");
    chk("unstall.ifid_pc", w_ifid_pc, 32'd8);
    for (int k = 0; k < 3; k++) step("fetch2");

    set_in(1'b0, 1'b1, 32'h10, 1'b0); step("beq");
    chk("beq.pc", w_pc, 32'h10);
    set_in(1'b0, 1'b0, 32'h0, 1'b0); step("beq_next");
    chk("beq_next.ifid_pc", w_ifid_pc, 32'h10);

    set_in(1'b1, 1'b1, 32'h23, 1'b0); step("redir_stall");
    chk("redir_stall.pc", w_pc, 32'h20);
    set_in(1'b0, 1'b0, 32'h0, 1'b0); step("fetch3");

    set_in(1'b0, 1'b1, 32'h14, 1'b0); step("to14");
    set_in(1'b0, 1'b1, 32'h80, 1'b1); step("halt");
    chk("halt.pc", w_pc, 32'h14);
    for (int k = 0; k < 10; k++) begin
      set_in(k[0], k[1], 32'h100 + k, k[2]);
      step("halted");
    end

    #2 w_rst = 1'b1; #2 w_rst = 1'b0;
    model_reset();
    set_in(1'b0, 1'b1, 32'h3C, 1'b0); step("boot_redir");
    set_in(1'b0, 1'b0, 32'h0, 1'b0); step("fetch3c");
    chk("pre_async.pc", w_pc, 32'h40);

    #3 w_rst = 1'b1;
    #1;
    chk("async.pc", w_pc, 32'h0);
    chk("async.valid", {31'd0, w_ifid_valid}, 32'd0);
    chk("async.cnt", w_fetch_cnt, 32'd0);
    #1 w_rst = 1'b0;
    model_reset();
    step("reboot");
    step("refetch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
